map_lane_sched: RTL and testbench

//  Frame scheduler for parallel perspective-mapping lanes (each a pixel_map-style divider engine).

---
 rtl/map_lane_sched_pkg.sv | 29 ++
 rtl/map_lane_sched_if.sv | 37 +++
 rtl/map_lane_sched_rr_arbiter.sv | 44 ++++
 rtl/map_lane_sched.sv | 163 ++++++++++++++++
 tb/tb_map_lane_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_lane_sched_pkg.sv
// ============================================================================
// map_lane_sched_pkg : shared state encoding and raster constants for the
//                      perspective-mapping lane scheduler.
// Revision 1.0
// ============================================================================
`default_nettype none

package map_lane_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    localparam int XMAX_DFLT    = 639;
    localparam int YMAX_DFLT    = 479;
    localparam int PIX_W_DFLT   = 12;
    localparam int COORD_W      = 10;
    localparam int FRAME_PIXELS = (XMAX_DFLT + 1) * (YMAX_DFLT + 1);
    localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_lane_sched_if.sv
// ============================================================================
// map_lane_sched_if : lane dispatch, lane result and vga_buf write signals.
// Revision 1.0
// ============================================================================
`default_nettype none

interface map_lane_sched_if #(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 17,
    parameter int PIX_W     = 12
);
    logic [NUM_LANES-1:0]        lane_idle;
    logic [NUM_LANES-1:0]        lane_start;
    logic [9:0]                  lane_x;
    logic [9:0]                  lane_y;
    logic [NUM_LANES-1:0]        lane_wr_req;
    logic [NUM_LANES*ADDR_W-1:0] lane_wr_addr;
    logic [NUM_LANES*PIX_W-1:0]  lane_wr_pixel;
    logic [NUM_LANES-1:0]        lane_wr_ack;
    logic                        vga_in_wr;
    logic [ADDR_W-1:0]           vga_in_addr;
    logic [PIX_W-1:0]            pixel_out;

    modport master (
        input  lane_idle, lane_wr_req, lane_wr_addr, lane_wr_pixel,
        output lane_start, lane_x, lane_y, lane_wr_ack,
               vga_in_wr, vga_in_addr, pixel_out
    );

    modport slave (
        output lane_idle, lane_wr_req, lane_wr_addr, lane_wr_pixel,
        input  lane_start, lane_x, lane_y, lane_wr_ack,
               vga_in_wr, vga_in_addr, pixel_out
    );
endinterface

`default_nettype wire

// File: rtl/map_lane_sched_rr_arbiter.sv
// ============================================================================
// map_lane_sched_rr_arbiter : round-robin pick of the first request at or
//                             after ptr, one-hot grant plus index.
// Revision 1.0
// ============================================================================
`default_nettype none

module map_lane_sched_rr_arbiter
    import map_lane_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/map_lane_sched.sv
// ============================================================================
// map_lane_sched : walks the raster, dispatches coordinates to idle lanes and
//                  funnels lane results onto the single vga_buf write port.
// Revision 1.0
// ============================================================================
`default_nettype none

module map_lane_sched
    import map_lane_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 17,
    parameter int PIX_W     = PIX_W_DFLT,
    parameter int XMAX      = XMAX_DFLT,
    parameter int YMAX      = YMAX_DFLT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_go,
    output logic             frame_busy,
    output logic             frame_done,
    map_lane_sched_if.master bus
);

    localparam int                   IW    = idx_w(NUM_LANES);
    localparam logic [CNT_W-1:0]     TOTAL = CNT_W'((XMAX + 1) * (YMAX + 1));
    localparam logic [COORD_W-1:0]   XLAST = COORD_W'(XMAX);
    localparam logic [COORD_W-1:0]   YLAST = COORD_W'(YMAX);

    state_t               state;
    state_t               state_nx;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [NUM_LANES-1:0] issued_last;
    logic [IW-1:0]        rr_d;
    logic [IW-1:0]        rr_w;
    logic [CNT_W-1:0]     written;
    logic                 pending;

    logic [NUM_LANES-1:0] eligible;
    logic [NUM_LANES-1:0] d_grant;
    logic [NUM_LANES-1:0] w_grant;
    logic [IW-1:0]        d_idx;
    logic [IW-1:0]        w_idx;
    logic                 d_any;
    logic                 w_any;
    logic                 dispatch_fire;
    logic                 last_coord;
    logic [ADDR_W-1:0]    sel_addr;
    logic [PIX_W-1:0]     sel_pix;

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] i);
        return (i == IW'(NUM_LANES - 1)) ? '0 : i + IW'(1);
    endfunction

    // A lane that was just started may still report idle for one cycle.
    assign eligible      = bus.lane_idle & ~issued_last;
    assign dispatch_fire = (state == ST_DISPATCH) && d_any;
    assign last_coord    = (x == XLAST) && (y == YLAST);
    assign bus.lane_wr_ack = w_grant;

    map_lane_sched_rr_arbiter #(.N(NUM_LANES), .IW(IW)) u_disp_arb (
        .req   (eligible),
        .ptr   (rr_d),
        .grant (d_grant),
        .idx   (d_idx),
        .any   (d_any)
    );

    map_lane_sched_rr_arbiter #(.N(NUM_LANES), .IW(IW)) u_wr_arb (
        .req   (bus.lane_wr_req),
        .ptr   (rr_w),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_pix  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant[i]) begin
                sel_addr = sel_addr | bus.lane_wr_addr[i*ADDR_W +: ADDR_W];
                sel_pix  = sel_pix  | bus.lane_wr_pixel[i*PIX_W +: PIX_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:     if (frame_go || pending)          state_nx = ST_DISPATCH;
            ST_DISPATCH: if (dispatch_fire && last_coord)  state_nx = ST_DRAIN;
            ST_DRAIN:    if (written == TOTAL)             state_nx = ST_IDLE;
            default:                                       state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_busy      <= 1'b0;
            frame_done      <= 1'b0;
            pending         <= 1'b0;
            x               <= '0;
            y               <= '0;
            issued_last     <= '0;
            rr_d            <= '0;
            rr_w            <= '0;
            written         <= '0;
            bus.lane_start  <= '0;
            bus.lane_x      <= '0;
            bus.lane_y      <= '0;
            bus.vga_in_wr   <= 1'b0;
            bus.vga_in_addr <= '0;
            bus.pixel_out   <= '0;
        end else begin
            frame_busy <= (state_nx != ST_IDLE);
            frame_done <= (state == ST_DRAIN) && (written == TOTAL);

            // A go seen outside IDLE (including the completing cycle) is kept.
            if (state == ST_IDLE) pending <= 1'b0;
            else if (frame_go)    pending <= 1'b1;

            bus.lane_start <= '0;
            issued_last    <= '0;
            if (dispatch_fire) begin
                bus.lane_start <= d_grant;
                issued_last    <= d_grant;
                bus.lane_x     <= x;
                bus.lane_y     <= y;
                rr_d           <= ptr_next(d_idx);
                if (x == XLAST) begin
                    x <= '0;
                    y <= (y == YLAST) ? '0 : y + COORD_W'(1);
                end else begin
                    x <= x + COORD_W'(1);
                end
            end else if (state == ST_IDLE) begin
                x <= '0;
                y <= '0;
            end

            bus.vga_in_wr <= w_any;
            if (w_any) begin
                bus.vga_in_addr <= sel_addr;
                bus.pixel_out   <= sel_pix;
                rr_w            <= ptr_next(w_idx);
            end

            // Results landing while idle are stale and not part of any frame.
            if (state == ST_IDLE) written <= '0;
            else if (w_any)       written <= written + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_map_lane_sched.sv
// ============================================================================
// tb_map_lane_sched : randomized lane models with a raster/scoreboard reference
//                     for the lane scheduler, on a reduced 16x8 raster.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_map_lane_sched;

    localparam int NL   = 4;
    localparam int AW   = 17;
    localparam int PW   = 12;
    localparam int XM   = 15;
    localparam int YM   = 7;
    localparam int NPIX = (XM + 1) * (YM + 1);

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic frame_go = 1'b0;
    logic frame_busy;
    logic frame_done;

    int total = 0;
    int bad   = 0;

    map_lane_sched_if #(.NUM_LANES(NL), .ADDR_W(AW), .PIX_W(PW)) bus ();

    map_lane_sched #(
        .NUM_LANES(NL), .ADDR_W(AW), .PIX_W(PW), .XMAX(XM), .YMAX(YM)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_go   (frame_go),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix_of(input int a);
        int px;
        int py;
        px = a % (XM + 1);
        py = a / (XM + 1);
        return PW'((px * 37 + py * 101) ^ 32'h5a5);
    endfunction

    function automatic int rr_pick(input logic [NL-1:0] req, input int p);
        for (int k = 0; k < NL; k++) begin
            if (req[(p + k) % NL]) return (p + k) % NL;
        end
        return -1;
    endfunction

    // ---------------- lane models / manual drive ----------------
    bit            manual = 1'b0;
    logic [NL-1:0] man_idle = '0;
    logic [NL-1:0] man_req  = '0;
    logic [AW-1:0] man_addr [NL];
    logic [PW-1:0] man_pix  [NL];
    logic [NL-1:0] lane_en  = '1;
    int            lat_max  = 0;

    logic [NL-1:0] m_busy;
    logic [NL-1:0] m_req;
    int            m_cnt [NL];
    logic [9:0]    m_x   [NL];
    logic [9:0]    m_y   [NL];

    assign bus.lane_idle   = manual ? man_idle : (lane_en & ~m_busy);
    assign bus.lane_wr_req = manual ? man_req  : m_req;

    generate
        for (genvar g = 0; g < NL; g++) begin : g_lane
            assign bus.lane_wr_addr[g*AW +: AW] = manual ? man_addr[g]
                : AW'(int'(m_y[g]) * (XM + 1) + int'(m_x[g]));
            assign bus.lane_wr_pixel[g*PW +: PW] = manual ? man_pix[g]
                : pix_of(int'(m_y[g]) * (XM + 1) + int'(m_x[g]));
        end
    endgenerate

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= '0;
            m_req  <= '0;
            for (int i = 0; i < NL; i++) begin
                m_cnt[i] <= 0;
                m_x[i]   <= '0;
                m_y[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (bus.lane_start[i]) begin
                    m_busy[i] <= 1'b1;
                    m_req[i]  <= 1'b0;
                    m_cnt[i]  <= int'($urandom_range(lat_max, 0));
                    m_x[i]    <= bus.lane_x;
                    m_y[i]    <= bus.lane_y;
                end else if (m_req[i]) begin
                    if (bus.lane_wr_ack[i]) begin
                        m_req[i]  <= 1'b0;
                        m_busy[i] <= 1'b0;
                    end
                end else if (m_busy[i]) begin
                    if (m_cnt[i] == 0) m_req[i] <= 1'b1;
                    else               m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    // ---------------- raster / write scoreboard ----------------
    int            disp_cnt, disp_err, wr_cnt, wr_err, done_cnt, exp_x, exp_y;
    int            seen [NPIX];
    logic [NL-1:0] start_seen;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.lane_start != '0) begin
                disp_cnt++;
                start_seen = start_seen | bus.lane_start;
                if ($countones(bus.lane_start) != 1 || bus.lane_x !== 10'(exp_x) ||
                    bus.lane_y !== 10'(exp_y)) disp_err++;
                if (exp_x == XM) begin
                    exp_x = 0;
                    exp_y = (exp_y == YM) ? 0 : exp_y + 1;
                end else begin
                    exp_x++;
                end
            end
            if (bus.vga_in_wr) begin
                int a;
                a = int'(bus.vga_in_addr);
                wr_cnt++;
                if (a < NPIX) begin
                    seen[a]++;
                    if (bus.pixel_out !== pix_of(a)) wr_err++;
                end else begin
                    wr_err++;
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic clear_mon();
        disp_cnt = 0; disp_err = 0; wr_cnt = 0; wr_err = 0; done_cnt = 0;
        exp_x = 0; exp_y = 0; start_seen = '0;
        for (int i = 0; i < NPIX; i++) seen[i] = 0;
    endtask

    task automatic apply_reset();
        manual = 1'b0; frame_go = 1'b0; man_req = '0; man_idle = '0;
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
        clear_mon();
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 frame_go = 1'b1;
        @(posedge clk); #1 frame_go = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int c = 0; c < budget && done_cnt < target; c++) @(posedge clk);
    endtask

    function automatic int missing(input int frames);
        int m = 0;
        for (int i = 0; i < NPIX; i++) if (seen[i] != frames) m++;
        return m;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", frame_busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
        total++; if (bus.lane_start !== '0) begin bad++; $display("FAIL rst_start: got %h want 0", bus.lane_start); end
        total++; if (bus.lane_x !== '0 || bus.lane_y !== '0) begin bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", bus.lane_x, bus.lane_y); end
        total++; if (bus.vga_in_wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", bus.vga_in_wr); end
        total++; if (bus.vga_in_addr !== '0 || bus.pixel_out !== '0) begin bad++; $display("FAIL rst_wdata: got %h/%h want 0/0", bus.vga_in_addr, bus.pixel_out); end
        total++; if (bus.lane_wr_ack !== '0) begin bad++; $display("FAIL rst_ack: got %h want 0", bus.lane_wr_ack); end
    endtask

    task automatic test_one_lane();
        apply_reset();
        lane_en = 4'b0001; lat_max = 0;
        @(posedge clk); #1 frame_go = 1'b1;
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL go_busy_early: got %b want 0", frame_busy); end
        @(posedge clk); #1 frame_go = 1'b0;
        total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL go_busy_rise: got %b want 1", frame_busy); end
        wait_done(1, 20000);
        repeat (20) @(posedge clk);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL one_done: got %0d want 1", done_cnt); end
        total++; if (disp_cnt !== NPIX) begin bad++; $display("FAIL one_disp: got %0d want %0d", disp_cnt, NPIX); end
        total++; if (disp_err !== 0) begin bad++; $display("FAIL one_order: got %0d errors want 0", disp_err); end
        total++; if (start_seen !== 4'b0001) begin bad++; $display("FAIL one_lanes: got %b want 0001", start_seen); end
        total++; if (wr_cnt !== NPIX || wr_err !== 0) begin bad++; $display("FAIL one_writes: got %0d/%0d err want %0d/0", wr_cnt, wr_err, NPIX); end
        total++; if (missing(1) !== 0) begin bad++; $display("FAIL one_cover: got %0d missing want 0", missing(1)); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL one_busy_end: got %b want 0", frame_busy); end
    endtask

    task automatic test_back_to_back();
        int            p, prev, e, q;
        logic [NL-1:0] last, exp_oh;
        apply_reset();
        manual = 1'b1; man_idle = '1;
        for (int i = 0; i < NL; i++) begin
            man_addr[i] = AW'($urandom); man_pix[i] = PW'($urandom);
        end
        @(posedge clk); #1 man_req = '1;
        p = 0; prev = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = rr_pick(man_req, p); exp_oh = '0; exp_oh[e] = 1'b1;
            total++; if (bus.lane_wr_ack !== exp_oh) begin bad++; $display("FAIL b2b_ack%0d: got %b want %b", k, bus.lane_wr_ack, exp_oh); end
            if (prev >= 0) begin
                total++;
                if (bus.vga_in_wr !== 1'b1 || bus.vga_in_addr !== man_addr[prev] || bus.pixel_out !== man_pix[prev]) begin
                    bad++; $display("FAIL b2b_wr%0d: got %b %h %h want 1 %h %h", k, bus.vga_in_wr, bus.vga_in_addr, bus.pixel_out, man_addr[prev], man_pix[prev]);
                end
            end
            prev = e; p = (e + 1) % NL;
        end
        @(posedge clk); #1 man_req = '0;
        pulse_go();
        for (int c = 0; c < 10 && bus.lane_start == '0; c++) @(negedge clk);
        q = 0; last = '0;
        for (int k = 0; k < 5; k++) begin
            e = rr_pick(man_idle & ~last, q); exp_oh = '0; exp_oh[e] = 1'b1;
            total++;
            if (bus.lane_start !== exp_oh || bus.lane_x !== 10'(k) || bus.lane_y !== 10'd0) begin
                bad++; $display("FAIL b2b_start%0d: got %b (%0d,%0d) want %b (%0d,0)", k, bus.lane_start, bus.lane_x, bus.lane_y, exp_oh, k);
            end
            last = exp_oh; q = (e + 1) % NL;
            @(negedge clk);
        end
    endtask

    task automatic test_arb_13();
        int e;
        apply_reset();
        manual = 1'b1;
        for (int i = 0; i < NL; i++) begin
            man_addr[i] = AW'($urandom); man_pix[i] = PW'($urandom);
        end
        @(posedge clk); #1 man_req = 4'b0010;
        @(negedge clk);
        total++; if (bus.lane_wr_ack !== 4'b0010) begin bad++; $display("FAIL arb_prime: got %b want 0010", bus.lane_wr_ack); end
        @(posedge clk); #1 man_req = 4'b1010;
        e = rr_pick(4'b1010, 2);
        @(negedge clk);
        total++; if (bus.lane_wr_ack !== 4'(1 << e)) begin bad++; $display("FAIL arb_first: got %b want %b", bus.lane_wr_ack, 4'(1 << e)); end
        @(posedge clk); #1 man_req = 4'b0010;
        @(negedge clk);
        total++; if (bus.vga_in_wr !== 1'b1 || bus.vga_in_addr !== man_addr[3] || bus.pixel_out !== man_pix[3]) begin bad++; $display("FAIL arb_wr3: got %b %h %h want 1 %h %h", bus.vga_in_wr, bus.vga_in_addr, bus.pixel_out, man_addr[3], man_pix[3]); end
        total++; if (bus.lane_wr_ack !== 4'b0010) begin bad++; $display("FAIL arb_second: got %b want 0010", bus.lane_wr_ack); end
        @(posedge clk); #1 man_req = '0;
        @(negedge clk);
        total++; if (bus.vga_in_wr !== 1'b1 || bus.vga_in_addr !== man_addr[1]) begin bad++; $display("FAIL arb_wr1: got %b %h want 1 %h", bus.vga_in_wr, bus.vga_in_addr, man_addr[1]); end
        @(negedge clk);
        total++; if (bus.vga_in_wr !== 1'b0) begin bad++; $display("FAIL arb_idle: got %b want 0", bus.vga_in_wr); end
    endtask

    task automatic test_lane_dead();
        apply_reset();
        lane_en = 4'b1011; lat_max = 5;
        pulse_go();
        wait_done(1, 20000);
        repeat (20) @(posedge clk);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL dead_done: got %0d want 1", done_cnt); end
        total++; if (start_seen !== 4'b1011) begin bad++; $display("FAIL dead_lanes: got %b want 1011", start_seen); end
        total++; if (disp_cnt !== NPIX || disp_err !== 0) begin bad++; $display("FAIL dead_disp: got %0d/%0d err want %0d/0", disp_cnt, disp_err, NPIX); end
        total++; if (wr_cnt !== NPIX || wr_err !== 0) begin bad++; $display("FAIL dead_writes: got %0d/%0d err want %0d/0", wr_cnt, wr_err, NPIX); end
        total++; if (missing(1) !== 0) begin bad++; $display("FAIL dead_cover: got %0d missing want 0", missing(1)); end
    endtask

    task automatic test_pending();
        apply_reset();
        lane_en = '1; lat_max = 3;
        pulse_go();
        for (int c = 0; c < 2000 && disp_cnt < 20; c++) @(posedge clk);
        pulse_go();
        repeat (3) @(posedge clk);
        pulse_go();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        total++; if (frame_done !== 1'b1 || frame_busy !== 1'b0) begin bad++; $display("FAIL pend_gap: got done=%b busy=%b want 1 0", frame_done, frame_busy); end
        @(negedge clk);
        total++; if (frame_busy !== 1'b1 || frame_done !== 1'b0) begin bad++; $display("FAIL pend_restart: got busy=%b done=%b want 1 0", frame_busy, frame_done); end
        wait_done(2, 5000);
        repeat (60) @(posedge clk);
        total++; if (done_cnt !== 2 || frame_busy !== 1'b0) begin bad++; $display("FAIL pend_frames: got %0d busy=%b want 2 0", done_cnt, frame_busy); end
        total++; if (disp_cnt !== 2 * NPIX || disp_err !== 0) begin bad++; $display("FAIL pend_disp: got %0d/%0d err want %0d/0", disp_cnt, disp_err, 2 * NPIX); end
        total++; if (wr_cnt !== 2 * NPIX || wr_err !== 0 || missing(2) !== 0) begin bad++; $display("FAIL pend_writes: got %0d/%0d err/%0d miss want %0d/0/0", wr_cnt, wr_err, missing(2), 2 * NPIX); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        lane_en = '1; lat_max = 2;
        pulse_go();
        for (int c = 0; c < 2000 && disp_cnt < 3 * (XM + 1) + 5; c++) @(posedge clk);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        total++; if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_flags: got busy=%b done=%b want 0 0", frame_busy, frame_done); end
        total++; if (bus.lane_start !== '0 || bus.lane_x !== '0 || bus.lane_y !== '0) begin bad++; $display("FAIL mid_disp: got %b (%0d,%0d) want 0 (0,0)", bus.lane_start, bus.lane_x, bus.lane_y); end
        total++; if (bus.vga_in_wr !== 1'b0 || bus.vga_in_addr !== '0 || bus.pixel_out !== '0) begin bad++; $display("FAIL mid_wr: got %b %h %h want 0 0 0", bus.vga_in_wr, bus.vga_in_addr, bus.pixel_out); end
        @(posedge clk); #3 reset_n = 1'b1;
        clear_mon();
        repeat (5) @(posedge clk);
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL mid_norestart: got %b want 0", frame_busy); end
        pulse_go();
        wait_done(1, 5000);
        repeat (20) @(posedge clk);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_done: got %0d want 1", done_cnt); end
        total++; if (disp_cnt !== NPIX || disp_err !== 0) begin bad++; $display("FAIL mid_order: got %0d/%0d err want %0d/0", disp_cnt, disp_err, NPIX); end
        total++; if (wr_cnt !== NPIX || wr_err !== 0 || missing(1) !== 0) begin bad++; $display("FAIL mid_writes: got %0d/%0d err/%0d miss want %0d/0/0", wr_cnt, wr_err, missing(1), NPIX); end
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            man_addr[i] = '0; man_pix[i] = '0;
        end
        clear_mon();
        test_reset();
        test_one_lane();
        test_back_to_back();
        test_arb_13();
        test_lane_dead();
        test_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
